// File: rtl/axi_lite_bram_ctrl_pkg.sv
// Shared definitions for the AXI4-Lite to 256x8 BRAM controller:
// default widths, controller state encoding and AXI response codes.
package axi_lite_bram_ctrl_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 32;
    localparam int MEM_W_DEF  = 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR_RESP = 2'd1,
        ST_RD_WAIT = 2'd2,
        ST_RD_DATA = 2'd3
    } state_e;

endpackage

// File: rtl/axi_lite_bram_ctrl.sv
// AXI4-Lite slave driving a falling-edge single-port BRAM; one transaction
// in flight, writes issue one cycle after both AW and W have been captured.
module axi_lite_bram_ctrl
    import axi_lite_bram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_W_DEF,
    parameter int DATA_WIDTH = DATA_W_DEF,
    parameter int MEM_WIDTH  = MEM_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_WIDTH-1:0]     s_awaddr,
    input  logic                      s_awvalid,
    output logic                      s_awready,
    input  logic [DATA_WIDTH-1:0]     s_wdata,
    input  logic [DATA_WIDTH/8-1:0]   s_wstrb,
    input  logic                      s_wvalid,
    output logic                      s_wready,
    output logic [1:0]                s_bresp,
    output logic                      s_bvalid,
    input  logic                      s_bready,
    input  logic [ADDR_WIDTH-1:0]     s_araddr,
    input  logic                      s_arvalid,
    output logic                      s_arready,
    output logic [DATA_WIDTH-1:0]     s_rdata,
    output logic [1:0]                s_rresp,
    output logic                      s_rvalid,
    input  logic                      s_rready,
    output logic                      bram_we,
    output logic [ADDR_WIDTH-1:0]     bram_addr,
    output logic [MEM_WIDTH-1:0]      bram_din,
    input  logic [MEM_WIDTH-1:0]      bram_dout
);

    state_e                  state_q;
    logic                    aw_held_q;
    logic                    w_held_q;
    logic [ADDR_WIDTH-1:0]   awaddr_q;
    logic [MEM_WIDTH-1:0]    wbyte_q;
    logic                    wstrb0_q;
    logic                    bvalid_q;
    logic                    rvalid_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    bram_we_q;
    logic [ADDR_WIDTH-1:0]   bram_addr_q;
    logic [MEM_WIDTH-1:0]    bram_din_q;

    logic idle_s;
    logic awready_s;
    logic wready_s;
    logic arready_s;
    logic wr_issue_s;
    logic unused_s;

    // Readies depend only on registered state; reset holds them low.
    always_comb begin
        idle_s     = (state_q == ST_IDLE) && !rst;
        awready_s  = idle_s && !aw_held_q;
        wready_s   = idle_s && !w_held_q;
        arready_s  = idle_s && !(aw_held_q && w_held_q);
        wr_issue_s = idle_s && aw_held_q && w_held_q;
    end

    // Controller FSM: channel capture, BRAM strobes and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            aw_held_q   <= 1'b0;
            w_held_q    <= 1'b0;
            awaddr_q    <= '0;
            wbyte_q     <= '0;
            wstrb0_q    <= 1'b0;
            bvalid_q    <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            bram_we_q   <= 1'b0;
            bram_addr_q <= '0;
            bram_din_q  <= '0;
        end else begin
            bram_we_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (wr_issue_s) begin
                        bram_addr_q <= awaddr_q;
                        bram_din_q  <= wbyte_q;
                        bram_we_q   <= wstrb0_q;
                        bvalid_q    <= 1'b1;
                        aw_held_q   <= 1'b0;
                        w_held_q    <= 1'b0;
                        state_q     <= ST_WR_RESP;
                    end else begin
                        if (s_awvalid && awready_s) begin
                            aw_held_q <= 1'b1;
                            awaddr_q  <= s_awaddr;
                        end
                        if (s_wvalid && wready_s) begin
                            w_held_q <= 1'b1;
                            wbyte_q  <= s_wdata[MEM_WIDTH-1:0];
                            wstrb0_q <= s_wstrb[0];
                        end
                        // A half-captured write does not block a read.
                        if (s_arvalid && arready_s) begin
                            bram_addr_q <= s_araddr;
                            state_q     <= ST_RD_WAIT;
                        end
                    end
                end
                ST_WR_RESP: begin
                    if (s_bready) begin
                        bvalid_q <= 1'b0;
                        state_q  <= ST_IDLE;
                    end
                end
                ST_RD_WAIT: begin
                    rdata_q  <= {{(DATA_WIDTH-MEM_WIDTH){1'b0}}, bram_dout};
                    rvalid_q <= 1'b1;
                    state_q  <= ST_RD_DATA;
                end
                ST_RD_DATA: begin
                    if (s_rready) begin
                        rvalid_q <= 1'b0;
                        state_q  <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign unused_s  = ^{s_wdata[DATA_WIDTH-1:MEM_WIDTH], s_wstrb[DATA_WIDTH/8-1:1]};

    assign s_awready = awready_s;
    assign s_wready  = wready_s;
    assign s_arready = arready_s;
    assign s_bresp   = RESP_OKAY;
    assign s_rresp   = RESP_OKAY;
    assign s_bvalid  = bvalid_q;
    assign s_rvalid  = rvalid_q;
    assign s_rdata   = rdata_q;
    assign bram_we   = bram_we_q;
    assign bram_addr = bram_addr_q;
    assign bram_din  = bram_din_q;

endmodule

// File: tb/tb_axi_lite_bram_ctrl.sv
// Bench for axi_lite_bram_ctrl: falling-edge BRAM model, cycle reference
// model checked every cycle, directed scenarios and randomized traffic.
module tb_axi_lite_bram_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  s_awaddr;
    logic        s_awvalid;
    logic        s_awready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_wvalid;
    logic        s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready;
    logic [7:0]  s_araddr;
    logic        s_arvalid;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid;
    logic        s_rready;
    logic        bram_we;
    logic [7:0]  bram_addr;
    logic [7:0]  bram_din;
    logic [7:0]  bram_dout;

    int total = 0;
    int bad   = 0;
    bit mdl_on = 1'b0;

    always #5 clk = ~clk;

    axi_lite_bram_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .s_awaddr  (s_awaddr),
        .s_awvalid (s_awvalid),
        .s_awready (s_awready),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .s_wvalid  (s_wvalid),
        .s_wready  (s_wready),
        .s_bresp   (s_bresp),
        .s_bvalid  (s_bvalid),
        .s_bready  (s_bready),
        .s_araddr  (s_araddr),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_rdata   (s_rdata),
        .s_rresp   (s_rresp),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready),
        .bram_we   (bram_we),
        .bram_addr (bram_addr),
        .bram_din  (bram_din),
        .bram_dout (bram_dout)
    );

    // Falling-edge BRAM: commits writes and registers read data at negedge.
    logic [7:0] bram_mem [256];
    always @(negedge clk) begin
        if (bram_we) bram_mem[bram_addr] <= bram_din;
        bram_dout <= bram_mem[bram_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: memory image plus per-channel obligations.
    logic [7:0]  ref_mem [256];
    bit          m_aw, m_w, m_b, m_rwait, m_r, m_we, m_strb;
    logic [7:0]  m_awaddr, m_wbyte, m_raddr, m_addr, m_din;
    logic [31:0] m_rdata;

    function automatic bit m_free();
        return !rst && !(m_b || m_rwait || m_r);
    endfunction

    always @(posedge clk) begin
        bit awr, wr, arr;
        awr = m_free() && !m_aw;
        wr  = m_free() && !m_w;
        arr = m_free() && !(m_aw && m_w);
        if (rst) begin
            m_aw = 0; m_w = 0; m_b = 0; m_rwait = 0; m_r = 0; m_we = 0;
            m_addr = 8'h00; m_din = 8'h00;
        end else begin
            m_we = 0;
            if (m_b) begin
                if (s_bready) m_b = 0;
            end else if (m_r) begin
                if (s_rready) m_r = 0;
            end else if (m_rwait) begin
                m_rwait = 0;
                m_r = 1;
                m_rdata = {24'h000000, ref_mem[m_raddr]};
            end else if (m_aw && m_w) begin
                m_we = m_strb; m_addr = m_awaddr; m_din = m_wbyte;
                if (m_strb) ref_mem[m_awaddr] = m_wbyte;
                m_b = 1; m_aw = 0; m_w = 0;
            end else begin
                if (s_arvalid && arr) begin m_rwait = 1; m_raddr = s_araddr; m_addr = s_araddr; end
                if (s_awvalid && awr) begin m_aw = 1; m_awaddr = s_awaddr; end
                if (s_wvalid && wr) begin m_w = 1; m_wbyte = s_wdata[7:0]; m_strb = s_wstrb[0]; end
            end
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (mdl_on) begin
                chk("m_awready", s_awready, m_free() && !m_aw);
                chk("m_wready", s_wready, m_free() && !m_w);
                chk("m_arready", s_arready, m_free() && !(m_aw && m_w));
                chk("m_bvalid", s_bvalid, m_b);
                chk("m_rvalid", s_rvalid, m_r);
                chk("m_bram_we", bram_we, m_we);
                chk("m_bram_addr", bram_addr, m_addr);
                chk("m_bram_din", bram_din, m_din);
                chk("m_resp", {s_bresp, s_rresp}, 4'h0);
                if (m_r) chk("m_rdata", s_rdata, m_rdata);
            end
        end
    end

    task automatic wr_chan(input bit do_aw, input bit do_w, input logic [7:0] a,
                           input logic [31:0] d, input logic [3:0] s);
        int n;
        bit aw_go, w_go;
        n = 0;
        s_awaddr = a; s_wdata = d; s_wstrb = s;
        s_awvalid = do_aw; s_wvalid = do_w;
        while ((s_awvalid || s_wvalid) && n < 40) begin
            aw_go = s_awvalid && s_awready;
            w_go  = s_wvalid && s_wready;
            @(negedge clk);
            if (aw_go) s_awvalid = 1'b0;
            if (w_go) s_wvalid = 1'b0;
            n++;
        end
        chk("wr_accept", (n < 40), 1'b1);
        s_awvalid = 1'b0; s_wvalid = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] d, output int lat);
        int n;
        n = 0;
        s_araddr = a; s_arvalid = 1'b1;
        while (!s_arready && n < 40) begin @(negedge clk); n++; end
        chk("rd_accept", (n < 40), 1'b1);
        @(negedge clk);
        s_arvalid = 1'b0;
        lat = 0;
        while (!s_rvalid && lat < 40) begin @(negedge clk); lat++; end
        d = s_rdata;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish want finish by 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int lat, n;
        bit b_seen, aw_rp, w_rp, ar_rp;
        rst = 1'b1;
        s_awaddr = 8'h00; s_awvalid = 1'b0; s_wdata = 32'h0; s_wstrb = 4'h0; s_wvalid = 1'b0;
        s_araddr = 8'h00; s_arvalid = 1'b0; s_bready = 1'b1; s_rready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            bram_mem[i] = 8'($urandom);
            ref_mem[i]  = bram_mem[i];
        end
        bram_mem[8'h00] = 8'h3A; bram_mem[8'h01] = 8'h7F; bram_mem[8'h02] = 8'hB2; bram_mem[8'h08] = 8'hFF;
        ref_mem[8'h00]  = 8'h3A; ref_mem[8'h01]  = 8'h7F; ref_mem[8'h02]  = 8'hB2; ref_mem[8'h08]  = 8'hFF;

        repeat (2) @(negedge clk);
        mdl_on = 1'b1;
        chk("rst_awready", s_awready, 1'b0);
        chk("rst_bvalid", s_bvalid, 1'b0);
        chk("rst_rvalid", s_rvalid, 1'b0);
        chk("rst_rdata", s_rdata, 32'h0);
        chk("rst_bram_we", bram_we, 1'b0);
        chk("rst_bram_addr", bram_addr, 8'h00);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_arready", s_arready, 1'b1);

        rd(8'h00, d, lat);
        chk("t1_rdata", d, 32'h0000003A);
        chk("t1_latency", lat, 1);

        wr_chan(1'b1, 1'b0, 8'h0C, 32'h0, 4'h0);
        @(negedge clk);
        wr_chan(1'b0, 1'b1, 8'h0C, 32'hABCDEF55, 4'h1);
        @(negedge clk);
        chk("t2_we", bram_we, 1'b1);
        chk("t2_addr", bram_addr, 8'h0C);
        chk("t2_din", bram_din, 8'h55);
        chk("t2_bvalid", s_bvalid, 1'b1);
        @(negedge clk);
        chk("t2_we_drop", bram_we, 1'b0);
        rd(8'h0C, d, lat);
        chk("t2_rdata", d, 32'h00000055);

        wr_chan(1'b1, 1'b1, 8'h01, 32'hDEADBEEF, 4'b1110);
        @(negedge clk);
        chk("t3_no_we", bram_we, 1'b0);
        chk("t3_bvalid", s_bvalid, 1'b1);
        chk("t3_bresp", s_bresp, 2'b00);
        @(negedge clk);
        rd(8'h01, d, lat);
        chk("t3_rdata", d, 32'h0000007F);

        s_rready = 1'b0;
        s_araddr = 8'h08; s_arvalid = 1'b1;
        chk("t4_arready", s_arready, 1'b1);
        @(negedge clk);
        s_arvalid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("t4_rvalid_hold", s_rvalid, 1'b1);
            chk("t4_rdata_hold", s_rdata, 32'h000000FF);
            chk("t4_ar_blocked", s_arready, 1'b0);
            @(negedge clk);
        end
        s_rready = 1'b1;
        @(negedge clk);
        chk("t4_rvalid_done", s_rvalid, 1'b0);

        s_bready = 1'b0;
        wr_chan(1'b1, 1'b1, 8'h30, 32'h44, 4'h1);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("t4_bvalid_hold", s_bvalid, 1'b1);
            chk("t4_aw_blocked", s_awready, 1'b0);
            @(negedge clk);
        end
        s_bready = 1'b1;
        @(negedge clk);
        chk("t4_bvalid_done", s_bvalid, 1'b0);

        wr_chan(1'b1, 1'b1, 8'h20, 32'h99, 4'h1);
        s_araddr = 8'h20; s_arvalid = 1'b1;
        chk("t5_ar_refused", s_arready, 1'b0);
        b_seen = 1'b0; n = 0;
        while (!s_arready && n < 40) begin
            if (s_bvalid) b_seen = 1'b1;
            @(negedge clk);
            n++;
        end
        chk("t5_b_first", b_seen, 1'b1);
        chk("t5_b_closed", s_bvalid, 1'b0);
        @(negedge clk);
        s_arvalid = 1'b0;
        n = 0;
        while (!s_rvalid && n < 40) begin @(negedge clk); n++; end
        chk("t5_rdata", s_rdata, 32'h00000099);
        @(negedge clk);

        s_araddr = 8'h05; s_arvalid = 1'b1;
        chk("t6_arready", s_arready, 1'b1);
        @(negedge clk);
        s_arvalid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rvalid_rst", s_rvalid, 1'b0);
        chk("t6_addr_rst", bram_addr, 8'h00);
        rst = 1'b0;
        @(negedge clk);
        rd(8'h02, d, lat);
        chk("t6_rdata", d, 32'h000000B2);
        chk("t6_latency", lat, 1);

        aw_rp = 1'b0; w_rp = 1'b0; ar_rp = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            if (s_awvalid && aw_rp) s_awvalid = 1'b0;
            if (s_wvalid && w_rp) s_wvalid = 1'b0;
            if (s_arvalid && ar_rp) s_arvalid = 1'b0;
            if (!s_awvalid && $urandom_range(0, 3) == 0) begin
                s_awvalid = 1'b1; s_awaddr = 8'($urandom_range(0, 15));
            end
            if (!s_wvalid && $urandom_range(0, 3) == 0) begin
                s_wvalid = 1'b1; s_wdata = $urandom; s_wstrb = 4'($urandom_range(0, 15));
            end
            if (!s_arvalid && $urandom_range(0, 2) == 0) begin
                s_arvalid = 1'b1; s_araddr = 8'($urandom_range(0, 15));
            end
            s_bready = 1'($urandom_range(0, 1));
            s_rready = 1'($urandom_range(0, 1));
            rst = ($urandom_range(0, 149) == 0);
            #1;
            aw_rp = s_awready; w_rp = s_wready; ar_rp = s_arready;
            @(negedge clk);
        end
        rst = 1'b0; s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
        s_bready = 1'b1; s_rready = 1'b1;
        repeat (6) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
